// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared sizing helpers for the programmable sequence detector
package seqdet_pkg;

  // Bits needed to hold a length in the range 0..max_len.
  function automatic int len_width(input int max_len);
    int w;
    w = 0;
    for (int i = 1; i < 32; i++) begin
      if (w == 0 && (1 << i) >= (max_len + 1)) w = i;
    end
    return w;
  endfunction

  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_SAT = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/seqdet_match_cmp.sv
// rtl/seqdet_match_cmp.sv - masked comparison of the low len_q history bits against the pattern
module seqdet_match_cmp
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] hist_n,
  input  logic [MAX_LEN-1:0] pat_q,
  input  logic [LEN_W-1:0]   len_q,
  output logic               hit
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign hit = (((hist_n ^ pat_q) & mask) == '0);

endmodule

// File: rtl/seqdet_prog.sv
// rtl/seqdet_prog.sv - programmable serial sequence detector with saturating match counter
module seqdet_prog
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               input_valid,
  input  logic               input_bit,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pattern_len,
  input  logic               overlap_en,
  input  logic               clear,
  output logic               output_indicator,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               cfg_err
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ind_q, ind_d;
  logic               accept, hit, len_bad, match;

  assign hist_n  = {hist_q[MAX_LEN-2:0], input_bit};
  assign fill_n  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  assign len_bad = (len_q == '0) || (len_q > LEN_W'(MAX_LEN));
  // load and clear both reset the history, so a bit in that cycle is never used
  assign accept  = input_valid && !load && !clear;
  assign match   = accept && !len_bad && (fill_n >= len_q) && hit;

  seqdet_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist_n (hist_n),
    .pat_q  (pat_q),
    .len_q  (len_q),
    .hit    (hit)
  );

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    ind_d  = match;

    if (accept) begin
      hist_d = hist_n;
      fill_d = (match && !ovl_q) ? '0 : fill_n;
    end
    if (match && cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load) begin
      pat_d  = pattern;
      len_d  = pattern_len;
      ovl_d  = overlap_en;
      hist_d = '0;
      fill_d = '0;
    end
    if (clear) begin
      cnt_d  = '0;
      hist_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      ind_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      ind_q  <= ind_d;
    end
  end

  assign output_indicator = ind_q;
  assign match_count      = cnt_q;
  assign count_sat        = (cnt_q == CNT_SAT);
  assign cfg_err          = len_bad;

endmodule

// File: tb/tb_seqdet_prog.sv
// tb/tb_seqdet_prog.sv - randomized and directed bench for seqdet_prog against a bit-queue model
module tb_seqdet_prog;
  import seqdet_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = len_width(MAX_LEN);

  logic               clock = 1'b0;
  logic               reset;
  logic               input_valid, input_bit, load, clear, overlap_en;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pattern_len;
  logic               ind_a, sat_a, cfg_a;
  logic [7:0]         cnt_a;
  logic               ind_b, sat_b, cfg_b;
  logic [1:0]         cnt_b;

  seqdet_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
    .clock (clock), .reset (reset), .input_valid (input_valid), .input_bit (input_bit),
    .load (load), .pattern (pattern), .pattern_len (pattern_len), .overlap_en (overlap_en),
    .clear (clear), .output_indicator (ind_a), .match_count (cnt_a), .count_sat (sat_a),
    .cfg_err (cfg_a)
  );

  seqdet_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut2 (
    .clock (clock), .reset (reset), .input_valid (input_valid), .input_bit (input_bit),
    .load (load), .pattern (pattern), .pattern_len (pattern_len), .overlap_en (overlap_en),
    .clear (clear), .output_indicator (ind_b), .match_count (cnt_b), .count_sat (sat_b),
    .cfg_err (cfg_b)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every accepted bit since the last reset/load/clear (or non-overlapping hit)
  int                 bits[$];
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  int                 m_n;
  bit                 exp_ind;

  function automatic bit cfg_ok();
    return (m_len >= 1) && (m_len <= MAX_LEN);
  endfunction

  task automatic model_reset();
    bits.delete();
    m_pat = '0; m_len = 0; m_ovl = 0; m_n = 0; exp_ind = 0;
  endtask

  task automatic model_edge(input logic v, input logic b, input logic ld, input logic clr);
    bit ok;
    exp_ind = 0;
    if (ld || clr) begin
      bits.delete();
      if (ld) begin
        m_pat = pattern; m_len = int'(pattern_len); m_ovl = overlap_en;
      end
      if (clr) m_n = 0;
    end else if (v) begin
      bits.push_back(int'(b));
      if (bits.size() > MAX_LEN) void'(bits.pop_front());
      if (cfg_ok() && bits.size() >= m_len) begin
        ok = 1;
        for (int k = 0; k < m_len; k++)
          if (bits[bits.size()-1-k] != int'(m_pat[k])) ok = 0;
        if (ok) begin
          exp_ind = 1;
          m_n++;
          if (!m_ovl) bits.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("indicator", 32'(ind_a), 32'(exp_ind));
    chk("count8", 32'(cnt_a), (m_n > 255) ? 32'd255 : 32'(m_n));
    chk("sat8", 32'(sat_a), 32'(m_n >= 255));
    chk("indicator2", 32'(ind_b), 32'(exp_ind));
    chk("count2", 32'(cnt_b), (m_n > 3) ? 32'd3 : 32'(m_n));
    chk("sat2", 32'(sat_b), 32'(m_n >= 3));
    chk("cfg_err", 32'(cfg_a), 32'(!cfg_ok()));
  endtask

  task automatic step(input logic v, input logic b, input logic ld, input logic clr);
    input_valid = v; input_bit = b; load = ld; clear = clr;
    @(posedge clock);
    model_edge(v, b, ld, clr);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] p, input int l, input logic o);
    pattern = p; pattern_len = LEN_W'(l); overlap_en = o;
    step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  task automatic feed(input logic [15:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, v[i], 1'b0, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0;
    input_valid = 0; input_bit = 0; load = 0; clear = 0; overlap_en = 0;
    pattern = '0; pattern_len = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    reset = 1'b1;

    // overlapping: 1101 in 1101101 hits after bits 4 and 7
    load_cfg(8'b1101, 4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b1101101, 7, 0);
    chk("ovl_on_cnt", 32'(cnt_a), 32'd2);

    // non-overlapping: only the first hit
    load_cfg(8'b1101, 4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b1101101, 7, 0);
    chk("ovl_off_cnt", 32'(cnt_a), 32'd1);

    // saturation of the 2-bit counter with consecutive len-1 hits
    load_cfg(8'b1, 1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b11111, 5, 0);
    chk("sat_cnt2", 32'(cnt_b), 32'd3);
    chk("sat_flag2", 32'(sat_b), 32'd1);

    // gaps of three idle cycles between pattern bits
    load_cfg(8'b1101, 4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b1101, 4, 3);
    chk("gap_cnt", 32'(cnt_a), 32'd1);

    // zero length never matches
    load_cfg(8'b0, 0, 1'b1);
    feed(16'hA5F0, 16, 0);
    chk("len0_cnt", 32'(cnt_a), 32'd1);
    // length above MAX_LEN is also invalid
    load_cfg(8'hFF, 9, 1'b1);
    feed(16'hFFFF, 16, 0);

    // load mid-pattern discards the partial history
    load_cfg(8'b1101, 4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b11, 2, 0);
    load_cfg(8'b1101, 4, 1'b1);
    feed(16'b01, 2, 0);
    chk("load_mid_cnt", 32'(cnt_a), 32'd0);
    feed(16'b1101, 4, 0);

    // clear with the final bit suppresses the hit
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b110, 3, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_final_cnt", 32'(cnt_a), 32'd0);

    // load and clear together
    feed(16'b110, 3, 0);
    pattern = 8'b10; pattern_len = LEN_W'(2); overlap_en = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    feed(16'b1010, 4, 0);

    // 8-bit counter saturation
    load_cfg(8'b1, 1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt8", 32'(cnt_a), 32'd255);

    // asynchronous reset in the middle of a pattern
    load_cfg(8'b1101, 4, 1'b1);
    feed(16'b110, 3, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_ind", 32'(ind_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_sat", 32'(sat_a), 32'd0);
    chk("rst_cfg_err", 32'(cfg_a), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    feed(16'b1101, 4, 0);
    load_cfg(8'b1101, 4, 1'b1);
    feed(16'b1101, 4, 0);
    chk("rst_reload_cnt", 32'(cnt_a), 32'd1);

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pattern = MAX_LEN'($urandom);
        pattern_len = ($urandom_range(0, 9) < 8) ? LEN_W'($urandom_range(1, 4))
                                                 : LEN_W'($urandom_range(0, 12));
        overlap_en = 1'($urandom_range(0, 1));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             1'($urandom_range(0, 3) == 0));
      end else if (r < 5) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seqdet_prog.md
# seqdet_prog

Programmable serial sequence detector: a parametrised successor to the team's fixed-pattern 3-bit-state detector. It watches a qualified serial bit stream for a run-time loadable pattern of 1..MAX_LEN bits. Each hit produces a registered one-cycle pulse and increments a saturating match counter. Overlapping or non-overlapping detection is selectable. It sits between the serial front end and the status/interrupt logic.

## Interface
- MAX_LEN, 8: longest supported pattern in bits; must be ≥ 2.
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): derived width of pattern_len; not to be overridden.
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- input_valid  in  1  qualifies input_bit for this cycle.
- input_bit  in  1  serial data bit.
- load  in  1  one-cycle strobe; latches pattern, pattern_len and overlap_en.
- pattern  in  MAX_LEN  pattern bits. pattern[len-1] is the first bit received; pattern[0] is the last.
- pattern_len  in  LEN_W  active pattern length.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- clear  in  1  synchronous clear of the counter and history.
- output_indicator  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  number of matches; saturates.
- count_sat  out  1  high while match_count is at all-ones.
- cfg_err  out  1  the latched length is invalid.

## Operation
- Registered config (pat_q, len_q, ovl_q) changes only on load.
- Reset config: all-zero pattern, len_q = 0, ovl_q = 0, so cfg_err = 1.
- History is hist (MAX_LEN bits) plus fill (0..MAX_LEN, saturating).
- On an accepted bit (input_valid, no load, no clear):
  - hist_n = {hist[MAX_LEN-2:0], input_bit}
  - fill_n = min(fill+1, MAX_LEN)
- A match occurs when all hold: len_q is valid, fill_n ≥ len_q, and hist_n[len_q-1:0] == pat_q[len_q-1:0].
- On a match:
  - output_indicator is set for one cycle.
  - match_count increments unless already saturated.
  - If ovl_q = 0, fill clears to 0, so the next match needs len_q fresh bits.
  - If ovl_q = 1, fill is kept.
- cfg_err = (len_q == 0) or (len_q > MAX_LEN). While cfg_err is high:
  - no matches are reported;
  - history still shifts.
- load:
  - latches the config;
  - clears hist and fill;
  - discards any bit presented in the same cycle;
  - leaves match_count unchanged.
- clear:
  - clears match_count, hist and fill;
  - discards any bit presented in the same cycle.
- load and clear in the same cycle: both take effect.
- match_count wraps never: it holds at 2^CNT_W-1 and count_sat stays high until clear or reset.

## Timing
- Reset (asynchronous assert, synchronous release): all outputs 0 except cfg_err = 1; hist, fill and match_count are 0.
- Latency: output_indicator is high in the cycle after the edge that samples the final pattern bit; match_count updates on that same edge.
- Back-to-back overlapping matches (e.g. len 1) give consecutive high cycles of output_indicator, one per match.
- Idle cycles (input_valid = 0) hold all state; output_indicator returns to 0.
- A config change becomes effective for the first bit accepted after the load edge.
- Reset asserted mid-pattern: partial history is lost immediately; no pulse is produced.

## Structure
- Package seqdet_pkg holds:
  - the function computing LEN_W from MAX_LEN;
  - a localparam for the counter saturation value, as a function of CNT_W.
- Sub-module seqdet_match_cmp: combinational masked comparator (hist_n, pat_q, len_q → hit).
- The top level owns the config registers, history/fill registers, counter and output register.

## Test plan
- Overlap on: pattern 4'b1101, len 4. Stream 1,1,0,1,1,0,1 → pulses after bits 4 and 7; match_count = 2.
- Overlap off: same pattern and stream → single pulse after bit 4; match_count = 1.
- Saturation: CNT_W = 2, pattern 1'b1, len 1, overlap on, five 1s → pulses on 5 consecutive cycles; match_count = 3; count_sat = 1.
- Gaps: pattern 1101 delivered with input_valid low for 3 cycles between each bit → one pulse, after the 4th valid bit only.
- Config and clear:
  - len 0 → cfg_err = 1, no pulses on any stream.
  - load in the middle of a pattern → history discarded, no false hit.
  - clear together with the final pattern bit → no pulse; count = 0.
- Reset: drive reset low in the middle of a pattern → outputs 0 asynchronously and cfg_err = 1; after release, a fresh load plus a full pattern is required to match.
